// File: rtl/sdram_arb_if.sv
// Requester, result and SDRAM-controller signals of the three-way SDRAM arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface sdram_arb_if #(
    parameter int AW = 25
);
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [15:0]   ld_wdata;
    logic          ld_ack;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [1:0]    cpu_be;
    logic [15:0]   cpu_wdata;
    logic          cpu_ack;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;

    logic [15:0]   rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_be;
    logic [15:0]   mem_wdata;
    logic          mem_ack;
    logic [15:0]   mem_rdata;

    modport slave (
        input  ld_req, ld_addr, ld_wdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        input  vid_req, vid_addr,
        input  mem_ack, mem_rdata,
        output ld_ack, cpu_ack, vid_ack, rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output ld_req, ld_addr, ld_wdata,
        output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        output vid_req, vid_addr,
        output mem_ack, mem_rdata,
        input  ld_ack, cpu_ack, vid_ack, rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/sdram_arb.sv
// Single-outstanding SDRAM arbiter: loader > video > CPU, with the CPU promoted over
// video once video has won STARVE_MAX grants in a row while the CPU was waiting.
module sdram_arb #(
    parameter int AW         = 25,
    parameter int STARVE_MAX = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    sdram_arb_if.slave bus
);
    localparam int             CW         = $clog2(STARVE_MAX + 2);
    localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_VID, OWN_CPU} owner_t;

    state_t        state, state_nx;
    owner_t        owner, winner;
    logic [CW-1:0] starve_cnt;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [1:0]    mem_be_q;
    logic [15:0]   mem_wdata_q;
    logic [15:0]   rdata_q;
    logic          grant;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        winner = OWN_NONE;
        if (bus.ld_req)
            winner = OWN_LD;
        else if (bus.vid_req && !(bus.cpu_req && starve_cnt == STARVE_LIM))
            winner = OWN_VID;
        else if (bus.cpu_req)
            winner = OWN_CPU;
    end

    assign grant = (state == IDLE) && (winner != OWN_NONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = BUSY;
            BUSY:    if (bus.mem_ack) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            owner       <= OWN_NONE;
            starve_cnt  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 2'b00;
            mem_wdata_q <= 16'h0000;
            rdata_q     <= 16'h0000;
        end else begin
            if (grant) begin
                owner <= winner;
                case (winner)
                    OWN_LD: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= bus.ld_addr;
                        mem_be_q    <= 2'b11;
                        mem_wdata_q <= bus.ld_wdata;
                    end
                    OWN_VID: begin
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.vid_addr;
                        mem_be_q    <= 2'b11;
                        mem_wdata_q <= 16'h0000;
                        if (bus.cpu_req && starve_cnt != STARVE_LIM)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                    OWN_CPU: begin
                        mem_we_q    <= bus.cpu_we;
                        mem_addr_q  <= bus.cpu_addr;
                        mem_be_q    <= bus.cpu_be;
                        mem_wdata_q <= bus.cpu_wdata;
                        starve_cnt  <= '0;
                    end
                    default: ;
                endcase
            end
            // Only a read completing in BUSY updates rdata; stray acks elsewhere are dropped.
            if (state == BUSY && bus.mem_ack && !mem_we_q)
                rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_req   = (state == BUSY);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.ld_ack    = (state == ACK) && (owner == OWN_LD);
    assign bus.vid_ack   = (state == ACK) && (owner == OWN_VID);
    assign bus.cpu_ack   = (state == ACK) && (owner == OWN_CPU);
endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 SHALL have parameter AW, default 25: SDRAM byte address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive video grants allowed while the CPU waits.
REQ-003 SHALL have port clk_sys  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port ld_req  in  1  loader write request; level, held until ld_ack.
REQ-006 SHALL have port ld_addr  in  AW  loader byte address.
REQ-007 SHALL have port ld_wdata  in  16  loader write data.
REQ-008 SHALL have port ld_ack  out  1  loader completion pulse.
REQ-009 SHALL have port cpu_req  in  1  CPU request; level, held until cpu_ack.
REQ-010 SHALL have port cpu_we  in  1  CPU write (1) / read (0).
REQ-011 SHALL have port cpu_addr  in  AW  CPU byte address.
REQ-012 SHALL have port cpu_be  in  2  CPU byte enables {hi,lo}.
REQ-013 SHALL have port cpu_wdata  in  16  CPU write data.
REQ-014 SHALL have port cpu_ack  out  1  CPU completion pulse.
REQ-015 SHALL have port vid_req  in  1  video read request; level, held until vid_ack.
REQ-016 SHALL have port vid_addr  in  AW  video byte address.
REQ-017 SHALL have port vid_ack  out  1  video completion pulse.
REQ-018 SHALL have port rdata  out  16  read data of the most recently completed read.
REQ-019 SHALL have port mem_req  out  1  request to SDRAM controller; held until mem_ack.
REQ-020 SHALL have port mem_we  out  1  write strobe to controller.
REQ-021 SHALL have port mem_addr  out  AW  address to controller.
REQ-022 SHALL have port mem_be  out  2  byte enables to controller.
REQ-023 SHALL have port mem_wdata  out  16  write data to controller.
REQ-024 SHALL have port mem_ack  in  1  one-cycle completion from controller.
REQ-025 SHALL have port mem_rdata  in  16  read data, valid with mem_ack.

Function
REQ-026 SHALL implement states IDLE, BUSY, ACK; IDLE->BUSY when any req is sampled high; BUSY->ACK on mem_ack; ACK->IDLE unconditionally.
REQ-027 SHALL select the winner in IDLE with priority ld > vid > cpu, except that cpu wins over vid when starve count == STARVE_MAX and cpu_req is high.
REQ-028 SHALL increment the starve count, saturating at STARVE_MAX, on each vid grant while cpu_req is high; it clears to 0 on a cpu grant.
REQ-029 SHALL latch the winner's addr, wdata, we and be at grant; requester input changes during BUSY/ACK have no effect.
REQ-030 SHALL drive a ld grant as mem_we=1, mem_be=2'b11; a vid grant as mem_we=0, mem_be=2'b11; a cpu grant as cpu_we and cpu_be.
REQ-031 SHALL assert mem_req from the cycle after the req is sampled until and including the cycle mem_ack is sampled, with mem_* stable throughout.
REQ-032 SHALL assert exactly one owner ack for exactly one cycle (state ACK), the cycle after mem_ack.
REQ-033 SHALL load rdata from mem_rdata on mem_ack for reads only; rdata is valid with the ack and holds until the next read completes.
REQ-034 SHALL ignore mem_ack in IDLE and ACK.
REQ-035 SHALL not re-grant a requester in the ACK cycle; requesters drop req in the cycle after their ack, so minimum back-to-back spacing is 3 cycles.

Reset
REQ-036 SHALL, on reset (including mid-BUSY), immediately force state IDLE, starve count 0, rdata 0, all acks 0 and all mem_* outputs 0, discarding any in-flight grant.

Verification
REQ-037 SHALL pass: cpu read at 0x100000, mem_ack 3 cycles after mem_req with mem_rdata=0xBEEF -> mem_req high 1 cycle after cpu_req, cpu_ack 1 cycle after mem_ack, rdata=0xBEEF.
REQ-038 SHALL pass: ld_req, vid_req and cpu_req raised on the same cycle -> grants in order ld, vid, cpu; one ack each.
REQ-039 SHALL pass: vid_req and cpu_req held continuously, STARVE_MAX=4 -> grant sequence vid x4, cpu, vid x4, cpu.
REQ-040 SHALL pass: ld write 0x1234 to 0x000002 -> mem_we=1, mem_be=2'b11, mem_wdata=0x1234, mem_addr=0x000002; rdata unchanged.
REQ-041 SHALL pass: cpu_addr changed from 0x200 to 0x400 during BUSY -> mem_addr stays 0x200 until mem_ack.
REQ-042 SHALL pass: reset pulsed during BUSY, then mem_ack arrives -> all outputs 0 on reset, no ack pulse afterwards, next request served normally.
